// File: rtl/adsr_envelope_if.sv
// Sample stream bundle for the ADSR envelope: the oscillator sample entering
// the voice and the enveloped sample leaving towards the mixer.
// The master drives sample_in/sample_valid and receives the scaled result;
// the slave (the envelope block) does the opposite.
interface adsr_envelope_if;
  logic [12:0] sample_in;
  logic        sample_valid;
  logic [12:0] sample_out;
  logic        sample_out_valid;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_out,
    input  sample_out_valid
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_out,
    output sample_out_valid
  );
endinterface

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator and two-stage amplitude scaler.
// The envelope level moves only on an internal tick every TICK_DIV clocks.
// Gate edges redirect the state machine and take priority over a coincident
// tick, whose level update is then dropped.
// Optional build macro ADSR_EXP_RELEASE_EN: the release step becomes
// max(1, (level * release_rate) >> ENV_W) for an exponential-style tail.
// Without it the release step is release_rate itself (linear release).
module adsr_envelope #(
  parameter int TICK_DIV = 2083,
  parameter int ENV_W    = 16
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             gate,
  input  logic [ENV_W-1:0] attack_rate,
  input  logic [ENV_W-1:0] decay_rate,
  input  logic [ENV_W-1:0] sustain_level,
  input  logic [ENV_W-1:0] release_rate,
  output logic [ENV_W-1:0] env_level,
  output logic             busy,
  adsr_envelope_if.slave   smp
);

  localparam int CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PROD_W = 13 + ENV_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [ENV_W-1:0] FULL = {ENV_W{1'b1}};

  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic              gate_q;
  logic              gate_rise;
  logic              gate_fall;
  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ENV_W-1:0]  level;
  logic [ENV_W-1:0]  level_nxt;
  logic [ENV_W:0]    att_sum;
  logic [ENV_W:0]    dec_thr;
  logic [ENV_W-1:0]  rel_step;
  logic [PROD_W-1:0] prod_q;
  logic              prod_valid_q;
  logic [12:0]       out_q;
  logic              out_valid_q;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Free-running tick divider, independent of the envelope state
  always_ff @(posedge CLK100MHZ) begin
    if (reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + CNT_W'(1);
  end

  // Gate history, so a gate already high out of reset counts as a rising edge
  always_ff @(posedge CLK100MHZ) begin
    if (reset) gate_q <= 1'b0;
    else gate_q <= gate;
  end

  assign gate_rise = gate & ~gate_q;
  assign gate_fall = ~gate & ((state == S_ATTACK) || (state == S_DECAY) ||
                              (state == S_SUSTAIN));

  // Extra top bit keeps the attack sum and the decay threshold from wrapping
  assign att_sum = {1'b0, level} + {1'b0, attack_rate};
  assign dec_thr = {1'b0, sustain_level} + {1'b0, decay_rate};

`ifdef ADSR_EXP_RELEASE_EN
  logic [ENV_W-1:0] rel_scaled;
  assign rel_scaled = ENV_W'(({{ENV_W{1'b0}}, level} * {{ENV_W{1'b0}}, release_rate}) >> ENV_W);
  assign rel_step   = (rel_scaled == '0) ? ENV_W'(1) : rel_scaled;
`else
  assign rel_step = release_rate;
`endif

  // Next state and level: gate edges first, otherwise per-state tick update
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (gate_rise) begin
      state_nxt = S_ATTACK;
    end else if (gate_fall) begin
      state_nxt = S_RELEASE;
    end else if (tick) begin
      case (state)
        S_ATTACK: begin
          if (att_sum >= {1'b0, FULL}) begin
            level_nxt = FULL;
            state_nxt = S_DECAY;
          end else begin
            level_nxt = att_sum[ENV_W-1:0];
          end
        end
        S_DECAY: begin
          if ({1'b0, level} <= dec_thr) begin
            level_nxt = sustain_level;
            state_nxt = S_SUSTAIN;
          end else begin
            level_nxt = level - decay_rate;
          end
        end
        S_SUSTAIN: level_nxt = sustain_level;
        S_RELEASE: begin
          if (level <= rel_step) begin
            level_nxt = '0;
            state_nxt = S_IDLE;
          end else begin
            level_nxt = level - rel_step;
          end
        end
        default: begin
          level_nxt = '0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Envelope state and level registers
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state <= S_IDLE;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  // Stage 1: full-width product with the level current in this cycle
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
    end else begin
      prod_q       <= PROD_W'(smp.sample_in) * PROD_W'(level);
      prod_valid_q <= smp.sample_valid;
    end
  end

  // Stage 2: drop the level fraction; output holds when no sample arrives
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= prod_valid_q;
      if (prod_valid_q) out_q <= 13'(prod_q >> ENV_W);
    end
  end

  assign smp.sample_out       = out_q;
  assign smp.sample_out_valid = out_valid_q;
  assign env_level            = level;
  assign busy                 = (state != S_IDLE);

endmodule
